vvc_bin_encoder: RTL and testbench

VVC_BIN_ENCODER -- requirements
Module: vvc_bin_encoder

---
 rtl/vvc_cabac_pkg.sv | 20 ++
 rtl/vvc_bin_encoder_lps_calc.sv | 22 ++
 rtl/vvc_bin_encoder.sv | 216 +++++++++++++++++++++
 tb/tb_vvc_bin_encoder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vvc_cabac_pkg.sv
// Shared CABAC definitions: arithmetic-coder register widths, reset range
// and the bin-encoder FSM state set.
package vvc_cabac_pkg;

  localparam int unsigned RANGE_W = 9;
  localparam int unsigned LOW_W   = 10;
  localparam int unsigned LPS_W   = 8;

  localparam logic [RANGE_W-1:0] RANGE_INIT = 9'd510;

  typedef enum logic [2:0] {
    IDLE,
    RENORM,
    EMIT,
    OUTST,
    FLUSH,
    TAIL
  } enc_state_e;

endpackage

// File: rtl/vvc_bin_encoder_lps_calc.sv
// LPS sub-range from context state and current range; the same formula is
// used on the decoder side so both paths stay bit-exact.
module lps_calc
  import vvc_cabac_pkg::*;
(
  input  logic [7:0]         i_state,
  input  logic [RANGE_W-1:0] i_range,
  output logic [LPS_W-1:0]   o_lps
);

  logic [7:0] w_q;
  logic [9:0] w_prod;
  logic [8:0] w_sum;

  always_comb begin
    w_q    = i_state[7] ? ~i_state : i_state;
    w_prod = 10'(w_q[7:2]) * 10'(i_range[8:5]);
    w_sum  = w_prod[9:1] + 9'd4;
    o_lps  = w_sum[7:0];
  end

endmodule

// File: rtl/vvc_bin_encoder.sv
// CABAC binary arithmetic encoder: one bin per transfer, bit-serial output
// with outstanding-bit resolution and slice-terminating flush.
module vvc_bin_encoder
  import vvc_cabac_pkg::*;
#(
  parameter int unsigned OUTST_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       bin,
  input  logic [7:0] state,
  input  logic       flush,
  output logic       bit_out,
  output logic       bit_valid,
  input  logic       bit_ready,
  output logic       done
);

  localparam logic [OUTST_W-1:0] OUTST_MAX = '1;

  enc_state_e          r_state;
  logic [RANGE_W-1:0]  r_range;
  logic [LOW_W-1:0]    r_low;
  logic [OUTST_W-1:0]  r_outst;
  logic                r_first;
  logic                r_flushing;
  logic                r_fin;
  logic                r_pend;
  logic                r_bit_out;
  logic                r_bit_valid;
  logic                r_done;
  logic [1:0]          r_tail_idx;

  logic [LPS_W-1:0]    w_lps;
  logic                w_xfer;
  logic [RANGE_W-1:0]  w_mps_range;
  logic [LOW_W-1:0]    w_lps_low;
  logic [RANGE_W-1:0]  w_sh_range;
  logic [LOW_W-1:0]    w_low_adj;
  logic                w_mid;
  logic                w_put;
  logic                w_put_bit;
  logic                w_put_fin;
  logic [RANGE_W-1:0]  w_put_range;
  enc_state_e          w_put_next;

  lps_calc u_lps (
    .i_state (state),
    .i_range (r_range),
    .o_lps   (w_lps)
  );

  // Where to go once every pending bit has been handed downstream.
  function automatic enc_state_e after_emit(input logic [RANGE_W-1:0] rng,
                                            input logic flushing,
                                            input logic fin);
    if (!rng[RANGE_W-1]) return RENORM;
    else if (!flushing)  return IDLE;
    else if (!fin)       return FLUSH;
    else                 return TAIL;
  endfunction

  always_comb begin
    w_xfer      = in_valid && (r_state == IDLE);
    w_mps_range = r_range - RANGE_W'(w_lps);
    w_lps_low   = r_low + LOW_W'(r_range) - LOW_W'(w_lps);
    w_sh_range  = {r_range[RANGE_W-2:0], 1'b0};
    w_mid       = (r_low[LOW_W-1:LOW_W-2] == 2'b01);
    w_low_adj   = r_low;
    w_put       = 1'b0;
    w_put_bit   = 1'b0;
    w_put_fin   = r_fin;
    w_put_range = r_range;
    if (r_state == RENORM) begin
      w_put_range = w_sh_range;
      if (r_low[LOW_W-1]) begin
        w_put     = 1'b1;
        w_put_bit = 1'b1;
        w_low_adj = r_low - 10'd512;
      end else if (w_mid) begin
        w_low_adj = r_low - 10'd256;
      end else begin
        w_put     = 1'b1;
      end
    end else if (r_state == FLUSH) begin
      w_put     = 1'b1;
      w_put_bit = r_low[LOW_W-1];
      w_put_fin = 1'b1;
    end
    w_put_next = after_emit(w_put_range, r_flushing, w_put_fin);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_range     <= RANGE_INIT;
      r_low       <= '0;
      r_outst     <= '0;
      r_first     <= 1'b1;
      r_flushing  <= 1'b0;
      r_fin       <= 1'b0;
      r_pend      <= 1'b0;
      r_bit_out   <= 1'b0;
      r_bit_valid <= 1'b0;
      r_done      <= 1'b0;
      r_tail_idx  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            if (flush) begin
              r_range    <= 9'd2;
              r_low      <= r_low + LOW_W'(r_range - 9'd2);
              r_flushing <= 1'b1;
              r_fin      <= 1'b0;
              r_state    <= RENORM;
            end else if (bin == state[7]) begin
              r_range <= w_mps_range;
              if (!w_mps_range[RANGE_W-1]) r_state <= RENORM;
            end else begin
              r_low   <= w_lps_low;
              r_range <= RANGE_W'(w_lps);
              r_state <= RENORM;
            end
          end
        end
        RENORM: begin
          r_range <= w_sh_range;
          r_low   <= {w_low_adj[LOW_W-2:0], 1'b0};
          if (w_mid && (r_outst != OUTST_MAX)) r_outst <= r_outst + OUTST_W'(1);
          if (!w_put) r_state <= after_emit(w_sh_range, r_flushing, r_fin);
        end
        FLUSH: r_fin <= 1'b1;
        EMIT: begin
          if (bit_ready) begin
            if (r_outst != '0) begin
              r_state   <= OUTST;
              r_bit_out <= ~r_pend;
            end else begin
              r_bit_valid <= 1'b0;
              r_state     <= after_emit(r_range, r_flushing, r_fin);
            end
          end
        end
        OUTST: begin
          if (bit_ready) begin
            r_outst <= r_outst - OUTST_W'(1);
            if (r_outst == OUTST_W'(1)) begin
              r_bit_valid <= 1'b0;
              r_state     <= after_emit(r_range, r_flushing, r_fin);
            end
          end
        end
        TAIL: begin
          case (r_tail_idx)
            2'd0: begin
              r_bit_valid <= 1'b1;
              r_bit_out   <= r_low[LOW_W-2];
              r_tail_idx  <= 2'd1;
            end
            2'd1: begin
              if (bit_ready) begin
                r_bit_out  <= 1'b1;
                r_tail_idx <= 2'd2;
              end
            end
            2'd2: begin
              if (bit_ready) begin
                r_bit_valid <= 1'b0;
                r_done      <= 1'b1;
                r_range     <= RANGE_INIT;
                r_low       <= '0;
                r_outst     <= '0;
                r_first     <= 1'b1;
                r_flushing  <= 1'b0;
                r_fin       <= 1'b0;
                r_tail_idx  <= '0;
                r_state     <= IDLE;
              end
            end
            default: r_tail_idx <= '0;
          endcase
        end
        default: r_state <= IDLE;
      endcase
      // A put overrides the state chosen above; the suppressed first bit
      // still releases its outstanding bits.
      if (w_put) begin
        r_pend <= w_put_bit;
        if (r_first) begin
          r_first <= 1'b0;
          if (r_outst != '0) begin
            r_state     <= OUTST;
            r_bit_valid <= 1'b1;
            r_bit_out   <= ~w_put_bit;
          end else begin
            r_state <= w_put_next;
          end
        end else begin
          r_state     <= EMIT;
          r_bit_valid <= 1'b1;
          r_bit_out   <= w_put_bit;
        end
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign bit_out   = r_bit_out;
  assign bit_valid = r_bit_valid;
  assign done      = r_done;

endmodule

// File: tb/tb_vvc_bin_encoder.sv
// Scoreboard bench for vvc_bin_encoder: a loop-level CABAC reference model
// queues expected bits; a negedge monitor checks every accepted output bit.
module tb_vvc_bin_encoder;

  localparam int unsigned OW = 3;
  localparam int OMAX = (1 << OW) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       bin;
  logic [7:0] st;
  logic       flush;
  logic       bit_out;
  logic       bit_valid;
  logic       bit_ready;
  logic       done;

  vvc_bin_encoder #(.OUTST_W(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin       (bin),
    .state     (st),
    .flush     (flush),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int exp_done = 0;
  int got_done = 0;
  bit mon_en   = 1'b0;
  bit rdy_hold = 1'b0;

  int m_range, m_low, m_outst;
  bit m_first;

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: textbook encoder loops on plain integers.
  task automatic model_reset();
    m_range = 510; m_low = 0; m_outst = 0; m_first = 1'b1;
  endtask

  function automatic int lps_of(input int s, input int rng);
    int q;
    q = (s >= 128) ? (s ^ 255) : s;
    return ((((q / 4) * (rng / 32)) / 2) + 4) % 256;
  endfunction

  task automatic put_bit(input int b);
    if (m_first) m_first = 1'b0;
    else exp_q.push_back(b);
    while (m_outst > 0) begin
      exp_q.push_back(1 - b);
      m_outst--;
    end
  endtask

  task automatic renorm();
    while (m_range < 256) begin
      if (m_low < 256) put_bit(0);
      else if (m_low >= 512) begin m_low -= 512; put_bit(1); end
      else begin
        m_low -= 256;
        if (m_outst < OMAX) m_outst++;
      end
      m_range = m_range * 2;
      m_low   = (m_low * 2) % 1024;
    end
  endtask

  task automatic model_bin(input int b, input int s);
    int l;
    l = lps_of(s, m_range);
    if (b == s / 128) m_range -= l;
    else begin
      m_low   = (m_low + m_range - l) % 1024;
      m_range = l;
    end
    renorm();
  endtask

  task automatic model_flush();
    m_range -= 2;
    m_low   = (m_low + m_range) % 1024;
    m_range = 2;
    renorm();
    put_bit((m_low / 512) % 2);
    exp_q.push_back((m_low / 256) % 2);
    exp_q.push_back(1);
    exp_done++;
    model_reset();
  endtask

  // Monitor: checks stall stability and pops one expectation per accepted bit.
  bit   prev_stall = 1'b0;
  logic prev_bit   = 1'b0;
  always @(negedge clk) begin
    if (!mon_en || rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", int'(bit_valid), 1);
        check("stall_bit", int'(bit_out), int'(prev_bit));
      end
      if (done) got_done++;
      if (bit_valid && bit_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_bit: got bit %0d expected none at %0t", bit_out, $time);
        end else begin
          check("bit", int'(bit_out), exp_q.pop_front());
        end
      end
      prev_stall = bit_valid && !bit_ready;
      prev_bit   = bit_out;
    end
  end

  initial begin
    bit_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bit_ready = rdy_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input bit b, input logic [7:0] s, input bit f);
    int n;
    @(negedge clk);
    in_valid = 1'b1; bin = b; st = s; flush = f;
    n = 0;
    while (!in_ready && n < 2000) begin @(negedge clk); n++; end
    check("send_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; bin = 1'b0; flush = 1'b0;
    if (f) model_flush();
    else model_bin(int'(b), int'(s));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((!in_ready || exp_q.size() != 0) && n < budget) begin @(negedge clk); n++; end
    @(negedge clk);
    check(name, int'(in_ready && exp_q.size() == 0), 1);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_range"}, int'(dut.r_range), m_range);
    check({tag, "_low"}, int'(dut.r_low), m_low);
    check({tag, "_outst"}, int'(dut.r_outst), m_outst);
  endtask

  initial begin
    int cnt;
    logic [7:0] s;
    bit f;
    rst = 1'b1; in_valid = 1'b0; bin = 1'b0; st = '0; flush = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_bit_valid", int'(bit_valid), 0);
    check("rst_done", int'(done), 0);
    check_regs("rst");

    // MPS bin without renormalisation: single-cycle turnaround.
    send(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("mps_in_ready", int'(in_ready), 1);
    check_regs("mps");

    // LPS from reset: six renorm cycles, all outstanding.
    do_reset();
    send(1'b1, 8'h00, 1'b0);
    cnt = 0;
    @(negedge clk);
    while (!in_ready && cnt < 100) begin cnt++; @(negedge clk); end
    check("renorm_cycles", cnt, 6);
    check_regs("lps");
    check("lps_no_bits", exp_q.size(), 0);

    // Put a 0 (suppressed first bit) releasing six 1s, under a 5-cycle stall.
    rdy_hold = 1'b1;
    send(1'b0, 8'h00, 1'b0);
    cnt = 0;
    while (!bit_valid && cnt < 100) begin @(negedge clk); cnt++; end
    check("emit_valid", int'(bit_valid), 1);
    repeat (5) @(negedge clk);
    rdy_hold = 1'b0;
    wait_idle("outst_drain", 500);
    check_regs("outst");

    // Flush from reset state.
    do_reset();
    send(1'b0, 8'h00, 1'b1);
    wait_idle("flush_drain", 500);
    check("flush_done", got_done, exp_done);
    check_regs("flush");

    // Reset in the middle of outstanding-bit emission.
    do_reset();
    send(1'b1, 8'h00, 1'b0);
    wait_idle("pre_rst_idle", 500);
    rdy_hold = 1'b1;
    send(1'b0, 8'h00, 1'b0);
    cnt = 0;
    while (!bit_valid && cnt < 100) begin @(negedge clk); cnt++; end
    check("midrst_valid", int'(bit_valid), 1);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_bit_valid", int'(bit_valid), 0);
    check("midrst_range", int'(dut.r_range), 510);
    exp_q.delete();
    model_reset();
    rdy_hold = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", int'(in_ready), 1);
    mon_en = 1'b1;
    check_regs("midrst");

    // Random bins with skewed contexts and occasional flushes.
    for (int i = 0; i < 300; i++) begin
      f = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) != 0)
        s = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'(8'hF8 | $urandom_range(0, 7));
      else
        s = 8'($urandom_range(0, 255));
      send(1'($urandom_range(0, 1)), s, f);
    end
    send(1'b0, 8'h00, 1'b1);
    wait_idle("final_drain", 5000);
    check("done_count", got_done, exp_done);
    check_regs("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
